// File: rtl/dnn_output_scoreboard_if.sv
// Handshake bundle between the DNN output port and its scoreboard.
// First-error capture signals exist only under SCOREBOARD_FIRST_ERR_EN.
interface dnn_output_scoreboard_if #(
  parameter int out_width = 1,
  parameter int cpc       = 6,
  parameter int win       = 16,
  parameter int cnt_width = 32
) ();
  localparam int CIW = $clog2(cpc);
  localparam int WEW = $clog2(win + 1);

  logic [CIW-1:0]       cycle_index;
  logic [out_width-1:0] a_out;
  logic [out_width-1:0] y_out;
  logic                 case_valid;
  logic                 case_error;
  logic [cnt_width-1:0] num_cases;
  logic [cnt_width-1:0] total_errors;
  logic [WEW-1:0]       window_errors;
  logic                 done;
`ifdef SCOREBOARD_FIRST_ERR_EN
  logic [cnt_width-1:0] first_err_case;
  logic [CIW-1:0]       first_err_idx;
  logic                 first_err_valid;
`endif

  modport master (
    output cycle_index, a_out, y_out,
`ifdef SCOREBOARD_FIRST_ERR_EN
    input  first_err_case, first_err_idx, first_err_valid,
`endif
    input  case_valid, case_error, num_cases,
    input  total_errors, window_errors, done
  );

  modport slave (
    input  cycle_index, a_out, y_out,
`ifdef SCOREBOARD_FIRST_ERR_EN
    output first_err_case, first_err_idx, first_err_valid,
`endif
    output case_valid, case_error, num_cases,
    output total_errors, window_errors, done
  );
endinterface

// File: rtl/dnn_output_scoreboard.sv
// Per-cycle-block output checker: case verdicts, totals, sliding window.
// Optional first-error capture via SCOREBOARD_FIRST_ERR_EN.
module dnn_output_scoreboard #(
  parameter int out_width   = 1,
  parameter int cpc         = 6,
  parameter int first_valid = 2,
  parameter int win         = 16,
  parameter int max_cases   = 1000,
  parameter int cnt_width   = 32
) (
  input logic clk,
  input logic reset,
  dnn_output_scoreboard_if.slave bus
);
  localparam int CIW = $clog2(cpc);
  localparam int WEW = $clog2(win + 1);
  localparam logic [cnt_width-1:0] MAX_C = cnt_width'(max_cases);
  // done is unreachable when max_cases exceeds the saturated count
  localparam bit DONE_OK = (cnt_width > 62) ||
    (longint'(max_cases) < (longint'(1) << cnt_width));

  logic                 err_acc_q, err_acc_d;
  logic                 case_valid_q, case_valid_d;
  logic                 case_error_q, case_error_d;
  logic [cnt_width-1:0] num_q, num_d;
  logic [cnt_width-1:0] tot_q, tot_d;
  logic [win-1:0]       hist_q, hist_d;
  logic [WEW-1:0]       werr_q, werr_d;
  logic                 done_q, done_d;
  logic                 mism, close, verdict;

  always_comb begin
    mism = (bus.a_out != bus.y_out) &&
           (bus.cycle_index >= CIW'(first_valid));
    close = (bus.cycle_index == CIW'(cpc - 1)) && !done_q;
    verdict = err_acc_q | mism;
    err_acc_d = close ? 1'b0 : verdict;
    case_valid_d = close;
    case_error_d = case_error_q;
    num_d = num_q;
    tot_d = tot_q;
    hist_d = hist_q;
    werr_d = werr_q;
    done_d = done_q;
    if (close) begin
      case_error_d = verdict;
      num_d = (num_q == '1) ? num_q : num_q + 1'b1;
      if (verdict && tot_q != '1)
        tot_d = tot_q + 1'b1;
      hist_d = {hist_q[win-2:0], verdict};
      werr_d = werr_q + WEW'(verdict) - WEW'(hist_q[win-1]);
      done_d = DONE_OK && (num_d == MAX_C);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_acc_q    <= 1'b0;
      case_valid_q <= 1'b0;
      case_error_q <= 1'b0;
      num_q        <= '0;
      tot_q        <= '0;
      hist_q       <= '0;
      werr_q       <= '0;
      done_q       <= 1'b0;
    end else begin
      err_acc_q    <= err_acc_d;
      case_valid_q <= case_valid_d;
      case_error_q <= case_error_d;
      num_q        <= num_d;
      tot_q        <= tot_d;
      hist_q       <= hist_d;
      werr_q       <= werr_d;
      done_q       <= done_d;
    end
  end

  assign bus.case_valid    = case_valid_q;
  assign bus.case_error    = case_error_q;
  assign bus.num_cases     = num_q;
  assign bus.total_errors  = tot_q;
  assign bus.window_errors = werr_q;
  assign bus.done          = done_q;

`ifdef SCOREBOARD_FIRST_ERR_EN
  logic                 fe_valid_q, fe_valid_d;
  logic [cnt_width-1:0] fe_case_q, fe_case_d;
  logic [CIW-1:0]       fe_idx_q, fe_idx_d;

  // case ordinal = closed cases so far plus the one in flight
  always_comb begin
    fe_valid_d = fe_valid_q;
    fe_case_d  = fe_case_q;
    fe_idx_d   = fe_idx_q;
    if (!fe_valid_q && mism) begin
      fe_valid_d = 1'b1;
      fe_case_d  = (num_q == '1) ? num_q : num_q + 1'b1;
      fe_idx_d   = bus.cycle_index;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fe_valid_q <= 1'b0;
      fe_case_q  <= '0;
      fe_idx_q   <= '0;
    end else begin
      fe_valid_q <= fe_valid_d;
      fe_case_q  <= fe_case_d;
      fe_idx_q   <= fe_idx_d;
    end
  end

  assign bus.first_err_valid = fe_valid_q;
  assign bus.first_err_case  = fe_case_q;
  assign bus.first_err_idx   = fe_idx_q;
`endif
endmodule
